// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: M pipeline register, writeback/Tnew decode, sub-word lane handling and a
// req/ack handshake to a variable-latency data memory with stall, misalignment and timeout.
module mem_stage_ctrl #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned LINK_REG = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [31:0]       in_instr,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_wdata,
  input  logic              dm_ack,
  input  logic [31:0]       dm_rdata,
  output logic [31:0]       instr_m,
  output logic [4:0]        rf_dst,
  output logic [1:0]        tnew,
  output logic              stall,
  output logic              dm_req,
  output logic              dm_we,
  output logic [3:0]        dm_be,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  output logic [31:0]       load_data,
  output logic              addr_err,
  output logic              bus_err
);

  localparam int unsigned     CntW    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MAX_WAIT - 1);

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpOri   = 6'h0d;
  localparam logic [5:0] OpLui   = 6'h0f;
  localparam logic [5:0] OpLb    = 6'h20;
  localparam logic [5:0] OpLh    = 6'h21;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpLbu   = 6'h24;
  localparam logic [5:0] OpLhu   = 6'h25;
  localparam logic [5:0] OpSb    = 6'h28;
  localparam logic [5:0] OpSh    = 6'h29;
  localparam logic [5:0] OpSw    = 6'h2b;
  localparam logic [5:0] FnJalr  = 6'h09;
  localparam logic [5:0] FnAddu  = 6'h21;
  localparam logic [5:0] FnSubu  = 6'h23;

  function automatic logic op_is_load(input logic [5:0] op);
    return op inside {OpLb, OpLh, OpLw, OpLbu, OpLhu};
  endfunction

  function automatic logic op_is_store(input logic [5:0] op);
    return op inside {OpSb, OpSh, OpSw};
  endfunction

  function automatic logic op_misaligned(input logic [5:0] op, input logic [1:0] lo);
    logic mis;
    case (op)
      OpLw, OpSw:        mis = (lo != 2'b00);
      OpLh, OpLhu, OpSh: mis = lo[0];
      default:           mis = 1'b0;
    endcase
    return mis;
  endfunction

  typedef enum logic {StIdle, StWait} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       instr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic [5:0] in_op;
  logic       in_mem_go;
  logic [5:0] op;
  logic [5:0] funct;
  logic       is_load;
  logic       st_wait;
  logic       timeout;

  logic [4:0]  dst;
  logic [3:0]  lane_be;
  logic [31:0] lane_wd;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] ld_ext;

  // A bubble is decoded as opcode 0 / funct 0, which is a nop.
  assign in_op     = in_valid ? in_instr[31:26] : 6'h00;
  assign in_mem_go = (op_is_load(in_op) | op_is_store(in_op)) &
                     ~op_misaligned(in_op, in_addr[1:0]);

  assign op      = instr_q[31:26];
  assign funct   = instr_q[5:0];
  assign is_load = op_is_load(op);
  assign st_wait = (state_q == StWait);
  assign timeout = st_wait & ~dm_ack & (cnt_q == CntLast);
  assign stall   = st_wait & ~dm_ack & ~timeout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (!stall) begin
      instr_q <= in_valid ? in_instr : 32'h0;
      addr_q  <= in_addr;
      wdata_q <= in_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Whenever M advances, the next state depends only on what is captured, which also
  // covers back-to-back accesses leaving and re-entering WAIT on the same edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (stall) begin
      state_d = StWait;
      cnt_d   = cnt_q + 1'b1;
    end else begin
      state_d = in_mem_go ? StWait : StIdle;
      cnt_d   = '0;
    end
  end

  always_comb begin
    dst     = 5'd0;
    lane_be = 4'b0000;
    lane_wd = 32'h0;
    rbyte   = dm_rdata[{addr_q[1:0], 3'b000} +: 8];
    rhalf   = addr_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    ld_ext  = 32'h0;

    case (op)
      OpRtype: if (funct inside {FnAddu, FnSubu, FnJalr}) dst = instr_q[15:11];
      OpAddi, OpOri, OpLui, OpLb, OpLh, OpLw, OpLbu, OpLhu: dst = instr_q[20:16];
      OpJal:   dst = 5'(LINK_REG);
      default: dst = 5'd0;
    endcase

    case (op)
      OpLw, OpSw: begin
        lane_be = 4'b1111;
        lane_wd = wdata_q;
      end
      OpLh, OpLhu, OpSh: begin
        lane_be = addr_q[1] ? 4'b1100 : 4'b0011;
        lane_wd = {2{wdata_q[15:0]}};
      end
      OpLb, OpLbu, OpSb: begin
        lane_be = 4'b0001 << addr_q[1:0];
        lane_wd = {4{wdata_q[7:0]}};
      end
      default: ;
    endcase

    case (op)
      OpLb:    ld_ext = {{24{rbyte[7]}}, rbyte};
      OpLbu:   ld_ext = {24'h0, rbyte};
      OpLh:    ld_ext = {{16{rhalf[15]}}, rhalf};
      OpLhu:   ld_ext = {16'h0, rhalf};
      OpLw:    ld_ext = dm_rdata;
      default: ld_ext = 32'h0;
    endcase

    instr_m   = instr_q;
    addr_err  = op_misaligned(op, addr_q[1:0]);
    bus_err   = timeout;
    dm_req    = st_wait & ~timeout;
    dm_we     = dm_req & op_is_store(op);
    dm_be     = dm_req ? lane_be : 4'b0000;
    dm_wdata  = dm_req ? lane_wd : 32'h0;
    dm_addr   = {addr_q[ADDR_W-1:2], 2'b00};
    load_data = (st_wait & dm_ack & is_load) ? ld_ext : 32'h0;
    tnew      = {1'b0, is_load & st_wait & ~dm_ack};
    rf_dst    = (addr_err | bus_err) ? 5'd0 : dst;
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: loads/stores with lane checks, stall hold, misalignment,
// timeout and asynchronous reset mid-access.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic [31:0] instr_m;
  logic [4:0]  rf_dst;
  logic [1:0]  tnew;
  logic        stall;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] load_data;
  logic        addr_err;
  logic        bus_err;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] InsLw   = 32'h8C880004;  // lw   $8,4($4)
  localparam logic [31:0] InsLb   = 32'h80090000;  // lb   $9,0($0)
  localparam logic [31:0] InsLbu  = 32'h90090000;  // lbu  $9,0($0)
  localparam logic [31:0] InsLh   = 32'h84090000;  // lh   $9,0($0)
  localparam logic [31:0] InsLhu  = 32'h94090000;  // lhu  $9,0($0)
  localparam logic [31:0] InsSb   = 32'hA0050000;  // sb   $5,0($0)
  localparam logic [31:0] InsSh   = 32'hA4050000;  // sh   $5,0($0)
  localparam logic [31:0] InsSw   = 32'hAC050000;  // sw   $5,0($0)
  localparam logic [31:0] InsOri  = 32'h340A0055;  // ori  $10,$0,0x55
  localparam logic [31:0] InsAddu = 32'h00221821;  // addu $3,$1,$2
  localparam logic [31:0] InsJal  = 32'h0C000000;  // jal
  localparam logic [31:0] InsLui  = 32'h3C070000;  // lui  $7,0

  mem_stage_ctrl #(
    .ADDR_W  (32),
    .MAX_WAIT(15),
    .LINK_REG(31)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_instr (in_instr),
    .in_addr  (in_addr),
    .in_wdata (in_wdata),
    .dm_ack   (dm_ack),
    .dm_rdata (dm_rdata),
    .instr_m  (instr_m),
    .rf_dst   (rf_dst),
    .tnew     (tnew),
    .stall    (stall),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_be    (dm_be),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .load_data(load_data),
    .addr_err (addr_err),
    .bus_err  (bus_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single edge, then a bubble.
  task automatic issue(input logic [31:0] instr, input logic [31:0] addr, input logic [31:0] wd);
    in_valid = 1'b1;
    in_instr = instr;
    in_addr  = addr;
    in_wdata = wd;
    step();
    in_valid = 1'b0;
    in_instr = 32'h0;
  endtask

  task automatic do_load(input string tag, input logic [31:0] instr, input logic [31:0] addr,
                         input int waits, input logic [31:0] rdata, input logic [31:0] exp_ld,
                         input logic [3:0] exp_be, input logic [4:0] exp_dst);
    issue(instr, addr, 32'h0);
    dm_ack = 1'b0;
    for (int i = 0; i < waits; i++) begin
      #1;
      check_eq({tag, "_stall"}, stall, 1);
      check_eq({tag, "_tnew"}, tnew, 1);
      check_eq({tag, "_req_w"}, dm_req, 1);
      check_eq({tag, "_ld0"}, load_data, 0);
      step();
    end
    dm_ack   = 1'b1;
    dm_rdata = rdata;
    #1;
    check_eq({tag, "_req"}, dm_req, 1);
    check_eq({tag, "_we"}, dm_we, 0);
    check_eq({tag, "_be"}, dm_be, exp_be);
    check_eq({tag, "_addr"}, dm_addr, addr & 32'hFFFF_FFFC);
    check_eq({tag, "_ld"}, load_data, exp_ld);
    check_eq({tag, "_dst"}, rf_dst, exp_dst);
    check_eq({tag, "_nostall"}, stall, 0);
    check_eq({tag, "_tnew0"}, tnew, 0);
    step();
    dm_ack = 1'b0;
    #1;
    check_eq({tag, "_idle"}, dm_req, 0);
  endtask

  task automatic do_store(input string tag, input logic [31:0] instr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd);
    issue(instr, addr, wd);
    dm_ack = 1'b0;
    #1;
    check_eq({tag, "_req"}, dm_req, 1);
    check_eq({tag, "_we"}, dm_we, 1);
    check_eq({tag, "_be"}, dm_be, exp_be);
    check_eq({tag, "_wd"}, dm_wdata, exp_wd);
    check_eq({tag, "_addr"}, dm_addr, addr & 32'hFFFF_FFFC);
    check_eq({tag, "_dst"}, rf_dst, 0);
    check_eq({tag, "_stall"}, stall, 1);
    check_eq({tag, "_tnew"}, tnew, 0);
    step();
    dm_ack = 1'b1;
    #1;
    check_eq({tag, "_wd_ack"}, dm_wdata, exp_wd);
    check_eq({tag, "_nostall"}, stall, 0);
    step();
    dm_ack = 1'b0;
  endtask

  task automatic do_alu(input string tag, input logic [31:0] instr, input logic [4:0] exp_dst);
    issue(instr, 32'h0, 32'h0);
    #1;
    check_eq({tag, "_dst"}, rf_dst, exp_dst);
    check_eq({tag, "_req"}, dm_req, 0);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_instr = 32'h0;
    in_addr  = 32'h0;
    in_wdata = 32'h0;
    dm_ack   = 1'b0;
    dm_rdata = 32'h0;
    #1;
    check_eq("rst_instr", instr_m, 0);
    check_eq("rst_req", dm_req, 0);
    check_eq("rst_stall", stall, 0);
    check_eq("rst_dst", rf_dst, 0);
    step();
    step();
    reset = 1'b0;

    // Zero-wait lw, then sub-word loads with lane select and extension.
    do_load("lw0", InsLw, 32'h100, 0, 32'hDEADBEEF, 32'hDEADBEEF, 4'b1111, 5'd8);
    do_load("lb", InsLb, 32'h103, 3, 32'h80112233, 32'hFFFFFF80, 4'b1000, 5'd9);
    do_load("lbu", InsLbu, 32'h103, 3, 32'h80112233, 32'h00000080, 4'b1000, 5'd9);
    do_load("lh", InsLh, 32'h102, 1, 32'h80112233, 32'hFFFF8011, 4'b1100, 5'd9);
    do_load("lhu", InsLhu, 32'h100, 0, 32'h80112233, 32'h00002233, 4'b0011, 5'd9);

    do_store("sh", InsSh, 32'h202, 32'h1234ABCD, 4'b1100, 32'hABCDABCD);
    do_store("sb", InsSb, 32'h201, 32'h000000EF, 4'b0010, 32'hEFEFEFEF);
    do_store("sw", InsSw, 32'h204, 32'h13579BDF, 4'b1111, 32'h13579BDF);

    do_alu("addu", InsAddu, 5'd3);
    do_alu("jal", InsJal, 5'd31);
    do_alu("lui", InsLui, 5'd7);
    do_alu("unk", 32'hFC000000, 5'd0);

    // M holds while stalled; the waiting ori is captured on the completion edge.
    issue(InsLw, 32'h100, 32'h0);
    in_valid = 1'b1;
    in_instr = InsOri;
    in_addr  = 32'h0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check_eq("hold_instr", instr_m, InsLw);
      step();
    end
    dm_ack = 1'b1;
    step();
    dm_ack   = 1'b0;
    in_valid = 1'b0;
    #1;
    check_eq("hold_next", instr_m, InsOri);
    check_eq("hold_dst", rf_dst, 10);
    check_eq("hold_req", dm_req, 0);

    // Back-to-back: sw captured on the lw completion edge issues immediately.
    issue(InsLw, 32'h100, 32'h0);
    dm_ack   = 1'b1;
    in_valid = 1'b1;
    in_instr = InsSw;
    in_addr  = 32'h104;
    in_wdata = 32'h11;
    step();
    in_valid = 1'b0;
    dm_ack   = 1'b0;
    #1;
    check_eq("b2b_req", dm_req, 1);
    check_eq("b2b_we", dm_we, 1);
    check_eq("b2b_addr", dm_addr, 32'h104);
    check_eq("b2b_stall", stall, 1);
    step();
    dm_ack = 1'b1;
    step();
    dm_ack = 1'b0;

    // Misaligned lw: no access, no stall, next instruction flows in.
    issue(InsLw, 32'h101, 32'h0);
    in_valid = 1'b1;
    in_instr = InsOri;
    #1;
    check_eq("mis_err", addr_err, 1);
    check_eq("mis_req", dm_req, 0);
    check_eq("mis_stall", stall, 0);
    check_eq("mis_dst", rf_dst, 0);
    step();
    in_valid = 1'b0;
    #1;
    check_eq("mis_next", instr_m, InsOri);
    check_eq("mis_clr", addr_err, 0);

    issue(InsSw, 32'h102, 32'h55);
    #1;
    check_eq("missw_err", addr_err, 1);
    check_eq("missw_we", dm_we, 0);
    check_eq("missw_be", dm_be, 0);

    // Timeout: 14 stalled cycles, bus_err in the 15th.
    issue(InsSw, 32'h300, 32'h5);
    for (int i = 1; i <= 14; i++) begin
      #1;
      check_eq("to_stall", stall, 1);
      check_eq("to_berr0", bus_err, 0);
      step();
    end
    #1;
    check_eq("to_berr", bus_err, 1);
    check_eq("to_nostall", stall, 0);
    check_eq("to_req", dm_req, 0);
    check_eq("to_dst", rf_dst, 0);
    step();
    #1;
    check_eq("to_after_berr", bus_err, 0);
    check_eq("to_after_req", dm_req, 0);

    // Asynchronous reset in the 2nd WAIT cycle of a load.
    issue(InsLw, 32'h100, 32'h0);
    #1;
    check_eq("ar_stall1", stall, 1);
    step();
    reset = 1'b1;
    #1;
    check_eq("ar_req", dm_req, 0);
    check_eq("ar_stall", stall, 0);
    check_eq("ar_instr", instr_m, 0);
    step();
    reset    = 1'b0;
    dm_ack   = 1'b1;
    dm_rdata = 32'hCAFEF00D;
    #1;
    check_eq("late_req", dm_req, 0);
    check_eq("late_ld", load_data, 0);
    check_eq("late_stall", stall, 0);
    step();
    dm_ack = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
